// File: rtl/satd_hadamard_8x16.sv
// SATD of a 16x8 pixel block: one row per clock goes through a difference,
// an 8-point Hadamard butterfly and an absolute-value sum into an accumulator.
module satd_hadamard_8x16 #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8,
  parameter int ITERATIONS = 15
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_INPUTS*WIDTH*(ITERATIONS+1)-1:0]   ORG,
  input  logic [NUM_INPUTS*WIDTH*(ITERATIONS+1)-1:0]   CUR,
  output logic [31:0]                                  satd_out,
  output logic                                         valid_out
);

  localparam int ROW_W = NUM_INPUTS * WIDTH;
  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam int DW    = WIDTH + 1;
  localparam int HW    = DW + 3;
  localparam int SUM_W = HW + 3;
  localparam int ACC_W = SUM_W + CNT_W;

  logic [CNT_W-1:0]        counter;
  logic [ACC_W-1:0]        acc;
  logic [ROW_W-1:0]        row_org;
  logic [ROW_W-1:0]        row_cur;
  logic signed [DW-1:0]    d  [NUM_INPUTS];
  logic signed [DW:0]      s1 [NUM_INPUTS];
  logic signed [DW+1:0]    s2 [NUM_INPUTS];
  logic signed [DW+2:0]    s3 [NUM_INPUTS];
  logic [HW-1:0]           mag [NUM_INPUTS];
  logic [SUM_W-1:0]        row_sum;
  logic [ACC_W-1:0]        total;

  always_comb begin
    row_org = ORG[int'(counter)*ROW_W +: ROW_W];
    row_cur = CUR[int'(counter)*ROW_W +: ROW_W];
    for (int p = 0; p < NUM_INPUTS; p++) begin
      d[p] = $signed({1'b0, row_org[p*WIDTH +: WIDTH]}) -
             $signed({1'b0, row_cur[p*WIDTH +: WIDTH]});
    end
  end

  // Three butterfly stages: distance 4, then 2 within each half, then 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1[i]   = d[i] + d[i+4];
      s1[i+4] = d[i] - d[i+4];
    end
    for (int h = 0; h < 8; h += 4) begin
      for (int i = 0; i < 2; i++) begin
        s2[h+i]   = s1[h+i] + s1[h+i+2];
        s2[h+i+2] = s1[h+i] - s1[h+i+2];
      end
    end
    for (int j = 0; j < 4; j++) begin
      s3[2*j]   = s2[2*j] + s2[2*j+1];
      s3[2*j+1] = s2[2*j] - s2[2*j+1];
    end
  end

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      mag[i]  = s3[i][HW-1] ? HW'(-s3[i]) : HW'(s3[i]);
      row_sum = row_sum + SUM_W'(mag[i]);
    end
    total = acc + ACC_W'(row_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      acc       <= '0;
      satd_out  <= '0;
      valid_out <= 1'b0;
    end else if (counter == CNT_W'(ITERATIONS)) begin
      satd_out  <= {{(32-ACC_W){1'b0}}, total};
      valid_out <= 1'b1;
      acc       <= '0;
      counter   <= '0;
    end else begin
      acc       <= total;
      counter   <= counter + 1'b1;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_satd_hadamard_8x16.sv
// Scoreboard bench for satd_hadamard_8x16: expected SATDs are queued when a
// block is applied and popped when valid_out pulses.
module tb_satd_hadamard_8x16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1023:0] org = '0;
  logic [1023:0] cur = '0;
  logic [31:0]   satd_out;
  logic          valid_out;

  int unsigned   exp_q[$];
  int            total = 0;
  int            bad   = 0;

  satd_hadamard_8x16 dut (
    .clk       (clk),
    .rst       (rst),
    .ORG       (org),
    .CUR       (cur),
    .satd_out  (satd_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference uses the matrix form H[u][x] = (-1)^popcount(u&x).
  function automatic int unsigned model_satd(input logic [1023:0] o, input logic [1023:0] c);
    int unsigned sum = 0;
    for (int r = 0; r < 16; r++) begin
      for (int u = 0; u < 8; u++) begin
        int coef = 0;
        for (int x = 0; x < 8; x++) begin
          int dv = int'(o[r*64 + x*8 +: 8]) - int'(c[r*64 + x*8 +: 8]);
          if ($countones(u & x) % 2 == 1) coef -= dv;
          else coef += dv;
        end
        sum += (coef < 0) ? -coef : coef;
      end
    end
    return sum;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts edges from the current block start until valid_out, checks timing,
  // hold of the previous result mid-block and the popped expected value.
  task automatic run_block(input string tag, input logic [31:0] prev);
    int got_cyc = 0;
    int unsigned exp_v;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 8) check_output({tag, "_hold"}, satd_out, prev);
      if (valid_out) begin
        got_cyc = cyc;
        break;
      end
    end
    check_output({tag, "_lat"}, got_cyc, 16);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_output({tag, "_satd"}, satd_out, exp_v);
  endtask

  task automatic apply_stimulus(input string tag, input logic [1023:0] o,
                                input logic [1023:0] c, input int unsigned exp_v);
    org = o;
    cur = c;
    do_reset();
    exp_q.push_back(exp_v);
    run_block(tag, 32'd0);
  endtask

  initial begin
    logic [1023:0] o;
    logic [1023:0] c;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_satd", satd_out, 32'd0);
    check_output("rst_valid", {31'd0, valid_out}, 32'd0);

    // Identical blocks, then a second block to confirm the 16-cycle period.
    o = {128{8'h5A}};
    apply_stimulus("equal", o, o, 0);
    exp_q.push_back(0);
    run_block("equal_rep", 32'd0);

    apply_stimulus("neg_one", '0, {128{8'h01}}, 128);

    apply_stimulus("full", {128{8'hFF}}, '0, 32640);
    exp_q.push_back(32640);
    run_block("full_rep", 32'd32640);

    o = '0;
    o[7:0] = 8'h03;
    apply_stimulus("row0_px0", o, '0, 24);

    o = '0;
    o[1023:1016] = 8'h03;
    apply_stimulus("row15_px7", o, '0, 24);

    o = '0;
    for (int i = 0; i < 128; i += 2) o[i*8 +: 8] = 8'h01;
    apply_stimulus("alternating", o, '0, 128);

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 128; i++) begin
        o[i*8 +: 8] = 8'($urandom);
        c[i*8 +: 8] = 8'($urandom);
      end
      apply_stimulus($sformatf("rand%0d", t), o, c, model_satd(o, c));
    end

    // Reset at counter=7: the old boundary must pass silently.
    org = {128{8'hFF}};
    cur = '0;
    do_reset();
    repeat (7) begin
      @(posedge clk);
      #1;
      check_output("mid_no_valid", {31'd0, valid_out}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_satd", satd_out, 32'd0);
    check_output("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    exp_q.push_back(32640);
    run_block("mid_rst", 32'd0);

    check_output("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
